// File: rtl/dfifo_elastic.sv
// dfifo_elastic: parametrised valid/ready dataflow FIFO for CGRA channels.
// Memory stage (_p0) feeds either a combinational head (fwft=1) or a
// registered output stage (_p1, fwft=0). Occupancy count and almost
// flags are registered. Defining DFIFO_STATS_EN adds the maxCount and
// pushStall statistics ports.
module dfifo_elastic #(
    parameter int dataWidth      = 32,
    parameter int fifoDepth      = 32,
    parameter int fwft           = 1,
    parameter int almostFullThr  = fifoDepth - 2,
    parameter int almostEmptyThr = 2,
    localparam int cntWidth = $clog2(fifoDepth + 2),
    localparam int ptrWidth = ($clog2(fifoDepth) > 1) ? $clog2(fifoDepth) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [dataWidth-1:0] din,
    input  logic                 dinValid,
    output logic                 dinReady,
    output logic [dataWidth-1:0] dout,
    output logic                 doutValid,
    input  logic                 doutReady,
    output logic [cntWidth-1:0]  count,
    output logic                 almostFull,
    output logic                 almostEmpty
`ifdef DFIFO_STATS_EN
    ,
    output logic [cntWidth-1:0]  maxCount,
    output logic [15:0]          pushStall
`endif
);

    localparam logic [cntWidth-1:0] DEPTH_C  = cntWidth'(fifoDepth);
    localparam logic [cntWidth-1:0] AF_C     = cntWidth'(almostFullThr);
    localparam logic [cntWidth-1:0] AE_C     = cntWidth'(almostEmptyThr);
    localparam logic [ptrWidth-1:0] LAST_PTR = ptrWidth'(fifoDepth - 1);

    logic [dataWidth-1:0] mem_p0 [fifoDepth];
    logic [ptrWidth-1:0]  wr_ptr;
    logic [ptrWidth-1:0]  rd_ptr;
    logic [cntWidth-1:0]  mem_count;
    logic [cntWidth-1:0]  mem_count_nxt;
    logic [cntWidth-1:0]  count_nxt;
    logic                 push;
    logic                 mem_pop;
    logic                 out_vld_nxt;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [ptrWidth-1:0] ptr_inc(input logic [ptrWidth-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered memory occupancy, never on doutReady.
    assign dinReady      = (mem_count != DEPTH_C);
    assign push          = dinValid && dinReady;
    assign mem_count_nxt = mem_count + cntWidth'(push) - cntWidth'(mem_pop);
    assign count_nxt     = mem_count_nxt + cntWidth'(out_vld_nxt);

    // Memory write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (push && !reset && !flush) begin
            mem_p0[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and flags; reset wins over flush, flush wins over traffic.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
            count       <= '0;
            almostFull  <= 1'b0;
            almostEmpty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (mem_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            mem_count   <= mem_count_nxt;
            count       <= count_nxt;
            almostFull  <= (count_nxt >= AF_C);
            almostEmpty <= (count_nxt <= AE_C);
        end
    end

    // ---- stage p0 -> output: head of memory or registered output stage ----
    if (fwft != 0) begin : g_fwft
        assign dout        = mem_p0[rd_ptr];
        assign doutValid   = (mem_count != '0);
        assign mem_pop     = doutValid && doutReady;
        assign out_vld_nxt = 1'b0;
    end else begin : g_oreg
        logic [dataWidth-1:0] data_p1;
        logic                 vld_p1;
        logic                 load;
        logic                 pop;

        assign load        = (mem_count != '0) && (!vld_p1 || doutReady);
        assign pop         = vld_p1 && doutReady;
        assign mem_pop     = load;
        assign out_vld_nxt = load || (vld_p1 && !pop);
        assign dout        = data_p1;
        assign doutValid   = vld_p1;

        // Output register: refills from memory when empty or being drained; data survives flush.
        always_ff @(posedge clock) begin
            if (reset) begin
                data_p1 <= '0;
                vld_p1  <= 1'b0;
            end else if (flush) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= out_vld_nxt;
                if (load) begin
                    data_p1 <= mem_p0[rd_ptr];
                end
            end
        end
    end

`ifdef DFIFO_STATS_EN
    // Peak occupancy and saturating producer-stall counter, cleared by reset or flush.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            maxCount  <= '0;
            pushStall <= '0;
        end else begin
            if (count_nxt > maxCount) begin
                maxCount <= count_nxt;
            end
            if (dinValid && !dinReady && (pushStall != 16'hFFFF)) begin
                pushStall <= pushStall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dfifo_elastic.sv
// tb_dfifo_elastic: two instances (fwft=1 depth 5, fwft=0 depth 4) driven by
// directed sequences and random traffic. Each instance has an occupancy
// model and a scoreboard queue; a separate monitor checks popped data.
module tb_dfifo_elastic;

    localparam int NI = 2;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush_w  [NI];
    logic [7:0]    din_w    [NI];
    logic          din_vld  [NI];
    logic          din_rdy  [NI];
    logic [7:0]    dout_w   [NI];
    logic          dout_vld [NI];
    logic          dout_rdy [NI];
    logic [CW-1:0] count_w  [NI];
    logic          af_w     [NI];
    logic          ae_w     [NI];
`ifdef DFIFO_STATS_EN
    logic [CW-1:0] max_w    [NI];
    logic [15:0]   stall_w  [NI];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int g, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                     nm, g, act, act, exp, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int DEP = (g == 0) ? 5 : 4;
        localparam int FW  = (g == 0) ? 1 : 0;
        localparam int AF  = DEP - 2;
        localparam int AE  = 2;

        dfifo_elastic #(
            .dataWidth(8),
            .fifoDepth(DEP),
            .fwft(FW)
        ) dut (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush_w[g]),
            .din        (din_w[g]),
            .dinValid   (din_vld[g]),
            .dinReady   (din_rdy[g]),
            .dout       (dout_w[g]),
            .doutValid  (dout_vld[g]),
            .doutReady  (dout_rdy[g]),
            .count      (count_w[g]),
            .almostFull (af_w[g]),
            .almostEmpty(ae_w[g])
`ifdef DFIFO_STATS_EN
            ,
            .maxCount   (max_w[g]),
            .pushStall  (stall_w[g])
`endif
        );

        // Reference state: n = words held, vis = head sitting in output register.
        logic [7:0] sb[$];
        int n = 0;
        int vis = 0;
        int mx = 0;
        int stall = 0;
        int memW;
        bit rdyE, dvE, pushE, popE, loadE;
        bit holdP = 1'b0;
        logic [7:0] holdD;
        logic [7:0] expD;

        // Model: check registered outputs, then advance occupancy for the coming edge.
        always @(negedge clock) begin
            memW = n - vis;
            rdyE = (memW < DEP);
            dvE  = (FW == 1) ? (n > 0) : (vis != 0);
            chk("count", g, int'(count_w[g]), n);
            chk("dinReady", g, int'(din_rdy[g]), int'(rdyE));
            chk("doutValid", g, int'(dout_vld[g]), int'(dvE));
            chk("almostFull", g, int'(af_w[g]), int'(n >= AF));
            chk("almostEmpty", g, int'(ae_w[g]), int'(n <= AE));
`ifdef DFIFO_STATS_EN
            chk("maxCount", g, int'(max_w[g]), mx);
            chk("pushStall", g, int'(stall_w[g]), stall);
`endif
            if (reset || flush_w[g]) begin
                n = 0;
                vis = 0;
                mx = 0;
                stall = 0;
                sb.delete();
            end else begin
                pushE = din_vld[g] && rdyE;
                popE  = dvE && dout_rdy[g];
                if (FW == 0) begin
                    loadE = (memW > 0) && ((vis == 0) || dout_rdy[g]);
                    vis = loadE ? 1 : (popE ? 0 : vis);
                end
                if (pushE) sb.push_back(din_w[g]);
                n = n + int'(pushE) - int'(popE);
                if (n > mx) mx = n;
                if (din_vld[g] && !rdyE && stall < 65535) stall++;
            end
        end

        // Monitor: compare each popped word with the scoreboard and check hold stability.
        always @(negedge clock) begin
            if (!reset && !flush_w[g] && dout_vld[g] && dout_rdy[g]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty[%0d]: got dout=0x%0h required no word available at %0t",
                             g, dout_w[g], $time);
                end else begin
                    expD = sb.pop_front();
                    chk("data", g, int'(dout_w[g]), int'(expD));
                end
            end
            if (holdP) begin
                chk("hold", g, int'(dout_w[g]), int'(holdD));
            end
            holdP = !reset && !flush_w[g] && dout_vld[g] && !dout_rdy[g];
            holdD = dout_w[g];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int g);
        din_vld[g]  = 1'b0;
        dout_rdy[g] = 1'b0;
        flush_w[g]  = 1'b0;
    endtask

    task automatic offer(input int g, input logic [7:0] d, input logic rdy);
        din_vld[g]  = 1'b1;
        din_w[g]    = d;
        dout_rdy[g] = rdy;
        step();
    endtask

    task automatic drain(input int g, input int cycles);
        din_vld[g]  = 1'b0;
        dout_rdy[g] = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        dout_rdy[g] = 1'b0;
    endtask

    int pv, pr;

    initial begin
        for (int g = 0; g < NI; g++) begin
            idle(g);
            din_w[g] = 8'h00;
        end
        step();
        step();
        reset = 1'b0;
        chk("reset_dout", 1, int'(dout_w[1]), 0);
        chk("reset_count", 0, int'(count_w[0]), 0);
        chk("reset_dinReady", 0, int'(din_rdy[0]), 1);

        // Fill depth-5 FWFT instance with 0x10..0x14, then drain in order.
        for (int k = 0; k < 5; k++) offer(0, 8'(8'h10 + k), 1'b0);
        din_vld[0] = 1'b0;
        chk("fill_count", 0, int'(count_w[0]), 5);
        chk("fill_dinReady", 0, int'(din_rdy[0]), 0);
        chk("fill_almostFull", 0, int'(af_w[0]), 1);
        step();
        drain(0, 6);
        chk("drain_doutValid", 0, int'(dout_vld[0]), 0);
        chk("drain_almostEmpty", 0, int'(ae_w[0]), 1);

        // Streaming through the wrap point.
        for (int k = 0; k < 12; k++) offer(0, 8'(k), 1'b1);
        drain(0, 3);

        // Registered-output instance: 5 words accepted, head held while stalled.
        for (int k = 0; k < 5; k++) offer(1, 8'(8'h20 + k), 1'b0);
        din_vld[1] = 1'b0;
        chk("oreg_count", 1, int'(count_w[1]), 5);
        chk("oreg_dout", 1, int'(dout_w[1]), 8'h20);
        for (int k = 0; k < 4; k++) step();
        drain(1, 8);

        // Full FIFO: pop with push offered is refused, accepted next cycle.
        for (int k = 0; k < 5; k++) offer(0, 8'(8'h30 + k), 1'b0);
        offer(0, 8'h40, 1'b1);
        chk("full_pop_count", 0, int'(count_w[0]), 4);
        offer(0, 8'h40, 1'b0);
        chk("full_refill_count", 0, int'(count_w[0]), 5);
        drain(0, 7);

        // Flush with a simultaneous push on both instances, then 0xAB follows.
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < NI; g++) begin
                din_vld[g] = 1'b1;
                din_w[g]   = 8'(8'h50 + k);
                dout_rdy[g] = 1'b0;
            end
            step();
        end
        for (int g = 0; g < NI; g++) begin
            flush_w[g] = 1'b1;
            din_w[g]   = 8'h55;
        end
        step();
        for (int g = 0; g < NI; g++) begin
            flush_w[g] = 1'b0;
            din_w[g]   = 8'hAB;
            chk("flush_count", g, int'(count_w[g]), 0);
            chk("flush_doutValid", g, int'(dout_vld[g]), 0);
            chk("flush_dinReady", g, int'(din_rdy[g]), 1);
        end
        step();
        for (int g = 0; g < NI; g++) din_vld[g] = 1'b0;
        for (int g = 0; g < NI; g++) dout_rdy[g] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        for (int g = 0; g < NI; g++) idle(g);

        // Statistics scenario: fill, 10 stalled offers, pop 2, then reset.
        flush_w[0] = 1'b1;
        step();
        flush_w[0] = 1'b0;
        for (int k = 0; k < 5; k++) offer(0, 8'(8'h60 + k), 1'b0);
        for (int k = 0; k < 10; k++) offer(0, 8'h6F, 1'b0);
        drain(0, 2);
`ifdef DFIFO_STATS_EN
        chk("stats_max", 0, int'(max_w[0]), 5);
        chk("stats_stall", 0, int'(stall_w[0]), 10);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef DFIFO_STATS_EN
        chk("stats_reset_max", 0, int'(max_w[0]), 0);
        chk("stats_reset_stall", 0, int'(stall_w[0]), 0);
`endif

        // Random traffic in three phases: filling, balanced, draining.
        for (int c = 0; c < 3000; c++) begin
            pv = (c < 1000) ? 80 : ((c < 2000) ? 50 : 30);
            pr = (c < 1000) ? 30 : ((c < 2000) ? 50 : 80);
            for (int g = 0; g < NI; g++) begin
                din_vld[g]  = ($urandom_range(0, 99) < pv);
                dout_rdy[g] = ($urandom_range(0, 99) < pr);
                din_w[g]    = 8'($urandom);
                flush_w[g]  = ($urandom_range(0, 63) == 0);
            end
            reset = (c == 1700);
            step();
        end
        reset = 1'b0;
        for (int g = 0; g < NI; g++) begin
            idle(g);
            dout_rdy[g] = 1'b1;
        end
        for (int k = 0; k < 10; k++) step();
        chk("leftover", 0, gi[0].sb.size(), 0);
        chk("leftover", 1, gi[1].sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
